// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared state encoding and sequence sizing for the gate vector sequencer
package gate_seq_pkg;
   typedef enum logic {IDLE, DRIVE} state_e;
   localparam int NUM_STEPS = 8;
   localparam int VEC_W = 3;
endpackage

// File: rtl/seq_result_checker.sv
// seq_result_checker: compares two gate outputs per step, counts mismatches, captures first failure and pass
module seq_result_checker
   import gate_seq_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             smp_i,
   input  logic             fin_i,
   input  logic [VEC_W-1:0] step_i,
   input  logic             y_a_i,
   input  logic             y_b_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [VEC_W-1:0] vec_o,
   output logic             valid_o,
   output logic             pass_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic             valid_q, valid_d, pass_q, pass_d, miss;

   assign miss = smp_i && (y_a_i != y_b_i);

   // next results: clear on run start, saturating count, first-fail capture, pass from final count
   always_comb begin
      cnt_d   = clr_i ? '0 : (miss && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
      valid_d = clr_i ? 1'b0 : (miss | valid_q);
      vec_d   = clr_i ? '0 : (miss && !valid_q) ? step_i : vec_q;
      pass_d  = clr_i ? 1'b0 : fin_i ? (cnt_d == '0) : pass_q;
   end

   // result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         valid_q <= valid_d;
         pass_q  <= pass_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign vec_o   = vec_q;
   assign valid_o = valid_q;
   assign pass_o  = pass_q;
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: walks {a,b,c} through all 8 vectors with programmable dwell and checks two gates
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               y_a,
   input  logic               y_b,
   output logic               a,
   output logic               b,
   output logic               c,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   mismatch_cnt,
   output logic [VEC_W-1:0]   first_bad_vec,
   output logic               first_bad_valid,
   output logic               pass
);
   localparam logic [VEC_W-1:0] LAST_STEP = VEC_W'(NUM_STEPS - 1);

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   step_q, step_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d, dlen_q, dlen_d;
   logic               done_q, done_d, clr, smp, fin;

   // next state: accept start in IDLE, hold each vector dlen cycles, sample on its last cycle
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      dcnt_d  = dcnt_q;
      dlen_d  = dlen_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      smp     = 1'b0;
      fin     = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            dlen_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
            step_d  = '0;
            dcnt_d  = '0;
            clr     = 1'b1;
            state_d = DRIVE;
         end
      end else if (dcnt_q != dlen_q - DWELL_W'(1)) begin
         dcnt_d = dcnt_q + DWELL_W'(1);
      end else begin
         smp    = 1'b1;
         dcnt_d = '0;
         if (step_q != LAST_STEP) begin
            step_d = step_q + VEC_W'(1);
         end else begin
            fin     = 1'b1;
            step_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   // sequencer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         dcnt_q  <= '0;
         dlen_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dcnt_q  <= dcnt_d;
         dlen_q  <= dlen_d;
         done_q  <= done_d;
      end
   end

   seq_result_checker #(.CNT_W(CNT_W)) u_chk (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .smp_i   (smp),
      .fin_i   (fin),
      .step_i  (step_q),
      .y_a_i   (y_a),
      .y_b_i   (y_b),
      .cnt_o   (mismatch_cnt),
      .vec_o   (first_bad_vec),
      .valid_o (first_bad_valid),
      .pass_o  (pass)
   );

   assign {a, b, c} = step_q;
   assign busy      = (state_q == DRIVE);
   assign done      = done_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: scoreboard bench driving AO gate models and checking run timing and results
module tb_gate_vector_sequencer;
   localparam int DWELL_W = 8;
   localparam int CNT_W   = 2;

   typedef struct {
      int d;
      int cnt;
      int vec;
      int valid;
      int pass;
   } exp_t;

   logic               clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic               y_a, y_b, a, b, c, busy, done, first_bad_valid, pass;
   logic [CNT_W-1:0]   mismatch_cnt;
   logic [2:0]         first_bad_vec;
   int                 inj_mode = 0;
   int                 errors = 0, checks = 0;
   exp_t               sb[$];
   exp_t               e;
   int                 mon_cyc = 0;
   logic               mon_pb = 1'b0, mon_pd = 1'b0;

   gate_vector_sequencer #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .dwell           (dwell),
      .y_a             (y_a),
      .y_b             (y_b),
      .a               (a),
      .b               (b),
      .c               (c),
      .busy            (busy),
      .done            (done),
      .mismatch_cnt    (mismatch_cnt),
      .first_bad_vec   (first_bad_vec),
      .first_bad_valid (first_bad_valid),
      .pass            (pass)
   );

   always #5 clk = ~clk;

   assign y_a = (a & b) | c;
   assign y_b = ((a & b) | c) ^ ((inj_mode == 2) || (inj_mode == 1 && {a, b, c} == 3'd3));

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic push_run(input int d, input int mode);
      exp_t x;
      x.d     = (d == 0) ? 1 : d;
      x.cnt   = (mode == 0) ? 0 : (mode == 1) ? 1 : 3;
      x.vec   = (mode == 1) ? 3 : 0;
      x.valid = (mode == 0) ? 0 : 1;
      x.pass  = (mode == 0) ? 1 : 0;
      sb.push_back(x);
   endtask

   task automatic start_run(input int d, input int mode);
      @(negedge clk);
      dwell    = DWELL_W'(d);
      inj_mode = mode;
      push_run(d, mode);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   task automatic wait_vec(input int v, input int lim);
      int n = 0;
      while (int'({a, b, c}) != v && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("vec_reached", int'({a, b, c}), v);
   endtask

   task automatic check_zero(input string tag);
      check(tag, int'({a, b, c, busy, done, mismatch_cnt, first_bad_vec, first_bad_valid, pass}), 0);
   endtask

   // monitor: per-cycle vector/timing checks and scoreboard pop on done
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_pb  = 1'b0;
            mon_pd  = 1'b0;
            mon_cyc = 0;
         end else begin
            if (mon_pd) check("done_pulse", int'(done), 0);
            if (busy && !mon_pb && sb.size() == 0) check("unexp_busy", 1, 0);
            if (busy && sb.size() != 0) begin
               check("vec", int'({a, b, c}), mon_cyc / sb[0].d);
               mon_cyc++;
            end
            if (done) begin
               if (sb.size() == 0) check("unexp_done", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("run_len", mon_cyc, 8 * e.d);
                  check("busy_end", int'(busy), 0);
                  check("vec_end", int'({a, b, c}), 0);
                  check("cnt", int'(mismatch_cnt), e.cnt);
                  check("bad_vec", int'(first_bad_vec), e.vec);
                  check("bad_valid", int'(first_bad_valid), e.valid);
                  check("pass", int'(pass), e.pass);
               end
               mon_cyc = 0;
            end
            mon_pb = busy;
            mon_pd = done;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("idle_after_reset");
      // basic run, D=1
      start_run(1, 0);
      wait_done(20);
      repeat (5) @(negedge clk);
      check("hold_pass", int'(pass), 1);
      // single mismatch at step 3, D=100
      start_run(100, 1);
      wait_done(1000);
      repeat (3) @(negedge clk);
      check("hold_cnt", int'(mismatch_cnt), 1);
      // zero dwell behaves as one
      start_run(0, 0);
      wait_done(20);
      // dwell change mid-run ignored
      start_run(3, 0);
      repeat (5) @(negedge clk);
      dwell = 8'd5;
      wait_done(40);
      // start during run ignored
      start_run(4, 0);
      wait_vec(4, 40);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(40);
      // saturation
      start_run(1, 2);
      wait_done(20);
      // back-to-back with start held, results cleared on second start
      @(negedge clk);
      dwell    = 8'd1;
      inj_mode = 2;
      push_run(1, 2);
      push_run(1, 0);
      start = 1'b1;
      wait_done(20);
      inj_mode = 0;
      @(negedge clk);
      check("b2b_busy", int'(busy), 1);
      check("b2b_clr_cnt", int'(mismatch_cnt), 0);
      check("b2b_clr_valid", int'(first_bad_valid), 0);
      start = 1'b0;
      wait_done(20);
      // reset mid-run during step 5
      start_run(2, 0);
      wait_vec(5, 40);
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      sb.delete(0);
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      repeat (20) @(negedge clk);
      start_run(1, 0);
      wait_done(20);
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
